// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell processes the operands LSB-first,
// with a registered carry between bits and a start/busy/done handshake.

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_a_sr;
    logic [N-1:0]   r_b_sr;
    logic [N-1:0]   r_s_sr;
    logic           r_c;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_s;
    logic           r_cout;
    logic           r_ovf;

    logic           w_fa_s;
    logic           w_fa_cout;
    logic           w_last_bit;

    fa u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_c),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    assign w_last_bit = (r_cnt == CW'(N - 1));

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the carry-into-MSB (r_c) is read before it updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are reset too, so a partial sum from an
            // aborted operation can never leak into a later result.
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_a_sr <= {1'b0, r_a_sr[N-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[N-1:1]};
                    r_s_sr <= {w_fa_s, r_s_sr[N-1:1]};
                    r_c    <= w_fa_cout;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last_bit) begin
                        // r_c here is the carry into the MSB
                        r_s     <= {w_fa_s, r_s_sr[N-1:1]};
                        r_cout  <= w_fa_cout;
                        r_ovf   <= r_c ^ w_fa_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8): vector table plus hand-written
// corner sequences, with a done-driven scoreboard checking results and latency.

module tb_serial_adder;
    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
        longint       t;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_push = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        exp_t       e;
        logic [N:0] sum;
        sum    = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
        e.s    = sum[N-1:0];
        e.cout = sum[N];
        e.ovf  = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
        e.t    = 0;
        return e;
    endfunction

    // Scoreboard: every done pulse pops one expected result and checks latency.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum", s, e.s);
                check("cout", cout, e.cout);
                check("ovf", ovf, e.ovf);
                check("latency", 32'(($time - e.t - 5) / 10), N);
            end
        end
    end

    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc, input exp_t e);
        int bcnt;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk);
        e.t = $time;
        sb_q.push_back(e);
        n_push++;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 4 * N) begin
            bcnt++;
            @(negedge clk);
        end
        check("busy_cycles", bcnt, N);
        check("done_pulse", done, 1'b1);
        @(negedge clk);
        check("done_single", done, 1'b0);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        check("drain", sb_q.size(), 0);
    endtask

    vec_t vecs[7];

    initial begin
        exp_t e;
        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hC0, 8'hBF, 1'b0, 8'h7F, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_s", s, 8'h00);
            check("rst_cout", cout, 1'b0);
            check("rst_ovf", ovf, 1'b0);
        end

        for (int i = 0; i < 7; i++) begin
            e.s = vecs[i].s; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf; e.t = 0;
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, e);
        end

        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] ra, rb;
            logic         rc;
            ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
            do_op(ra, rb, rc, model(ra, rb, rc));
        end

        // start during ADD is ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        e = '{8'h30, 1'b0, 1'b0, $time};
        sb_q.push_back(e);
        n_push++;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) begin
            @(negedge clk);
            check("ignored_start_idle", busy, 1'b0);
        end

        // start held high: one accept every N+2 cycles
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        e = '{8'h03, 1'b0, 1'b0, $time};
        sb_q.push_back(e);
        n_push++;
        for (int k = 0; k < 2; k++) begin
            repeat (N + 2) @(posedge clk);
            e.t = $time;
            sb_q.push_back(e);
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);

        // reset mid-ADD discards the partial result
        do_op(8'h35, 8'h4A, 1'b0, model(8'h35, 8'h4A, 1'b0));
        @(negedge clk);
        a = 8'h35; b = 8'h4A; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_s", s, 8'h00);
        check("abort_cout", cout, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        rst = 1'b0;
        repeat (N + 2) begin
            @(negedge clk);
            check("abort_quiet", {busy, done}, 2'b00);
        end
        do_op(8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0, 0});

        // result holds while inputs toggle with start low
        do_op(8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 0});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_s", s, 8'h80);
            check("hold_ovf", ovf, 1'b1);
            check("hold_cout", cout, 1'b0);
            check("hold_busy", busy, 1'b0);
            a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
        end

        check("done_count", n_done, n_push);
        check("queue_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
